// File: rtl/dmem_responder_if.sv
// ============================================================================
// Module : dmem_responder_if
// Desc   : H-style memory bus signal bundle between a master and dmem_responder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface dmem_responder_if;
  logic        HTRANS;
  logic [63:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HSIZE;
  logic [63:0] HWDATA;
  logic [63:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HTRANS, HADDR, HWRITE, HSIZE, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HTRANS, HADDR, HWRITE, HSIZE, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module : dmem_responder
// Desc   : Data RAM slave for the H-style bus: wait states, byte-lane writes,
//          two-cycle error response for out-of-range or misaligned accesses.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
  parameter int          DEPTH_WORDS = 512,
  parameter int          WAIT_STATES = 1
) (
  input  wire logic       CLK,
  input  wire logic       RESET,
  dmem_responder_if.slave bus
);

  localparam int          c_AW    = $clog2(8 * DEPTH_WORDS);
  localparam int          c_IW    = c_AW - 3;
  localparam logic [63:0] c_LIMIT = BASE_ADDR + 64'(8 * DEPTH_WORDS);
  localparam logic [2:0]  c_WAIT  = 3'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t      r_state;
  logic [63:0] r_addr;
  logic        r_write;
  logic [1:0]  r_size;
  logic [2:0]  r_wait;
  logic        r_hready;
  logic        r_hresp;
  logic [63:0] r_mem [DEPTH_WORDS];

  logic            w_accept;
  logic            w_misaligned;
  logic            w_out_of_range;
  logic            w_error;
  logic [63:0]     w_offset;
  logic [c_IW-1:0] w_index;
  logic [7:0]      w_size_mask;
  logic [7:0]      w_lane_mask;
  logic            w_commit;
  logic            w_read_data;
  logic            w_unused_offset;

  always_comb begin
    w_misaligned = 1'b0;
    case (bus.HSIZE)
      2'd1:    w_misaligned = bus.HADDR[0];
      2'd2:    w_misaligned = |bus.HADDR[1:0];
      2'd3:    w_misaligned = |bus.HADDR[2:0];
      default: w_misaligned = 1'b0;
    endcase
  end

  // The range check covers every upper address bit, so the index never wraps.
  assign w_out_of_range  = (bus.HADDR < BASE_ADDR) || (bus.HADDR >= c_LIMIT);
  assign w_error         = w_out_of_range || w_misaligned;
  assign w_accept        = bus.HTRANS && r_hready;

  assign w_offset        = r_addr - BASE_ADDR;
  assign w_index         = w_offset[c_AW-1:3];
  assign w_unused_offset = ^{w_offset[63:c_AW], w_offset[2:0]};

  always_comb begin
    w_size_mask = 8'h01;
    case (r_size)
      2'd0:    w_size_mask = 8'h01;
      2'd1:    w_size_mask = 8'h03;
      2'd2:    w_size_mask = 8'h0F;
      default: w_size_mask = 8'hFF;
    endcase
  end

  assign w_lane_mask = w_size_mask << r_addr[2:0];
  assign w_commit    = RESET && (r_state == S_DATA) && r_write;
  assign w_read_data = (r_state == S_DATA) && !r_write;

  assign bus.HRDATA  = w_read_data ? r_mem[w_index] : 64'h0;
  assign bus.HREADY  = r_hready;
  assign bus.HRESP   = r_hresp;

  // RAM contents deliberately survive reset.
  always_ff @(posedge CLK) begin
    if (w_commit) begin
      for (int b = 0; b < 8; b++) begin
        if (w_lane_mask[b]) begin
          r_mem[w_index][8*b +: 8] <= bus.HWDATA[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state  <= S_IDLE;
      r_hready <= 1'b1;
      r_hresp  <= 1'b0;
      r_wait   <= 3'd0;
      r_addr   <= 64'h0;
      r_write  <= 1'b0;
      r_size   <= 2'd0;
    end else begin
      case (r_state)
        S_WAIT: begin
          r_wait <= r_wait - 3'd1;
          if (r_wait == 3'd1) begin
            r_state  <= S_DATA;
            r_hready <= 1'b1;
          end
        end
        S_ERR1: begin
          r_state  <= S_ERR2;
          r_hready <= 1'b1;
          r_hresp  <= 1'b1;
        end
        default: begin
          // IDLE, DATA and ERR2 all present HREADY=1 and may accept.
          if (w_accept) begin
            r_addr  <= bus.HADDR;
            r_write <= bus.HWRITE;
            r_size  <= bus.HSIZE;
            if (w_error) begin
              r_state  <= S_ERR1;
              r_hready <= 1'b0;
              r_hresp  <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              r_state  <= S_WAIT;
              r_hready <= 1'b0;
              r_hresp  <= 1'b0;
              r_wait   <= c_WAIT;
            end else begin
              r_state  <= S_DATA;
              r_hready <= 1'b1;
              r_hresp  <= 1'b0;
            end
          end else begin
            r_state  <= S_IDLE;
            r_hready <= 1'b1;
            r_hresp  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module : tb_dmem_responder
// Desc   : Scoreboard bench driving three responders (0, 1 and 3 wait states).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_responder;

  typedef struct packed {
    logic [3:0]  low;
    logic        resp;
    logic [63:0] rdata;
  } exp_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [2:0]  rst_n;
  logic [2:0]  htrans;
  logic [2:0]  hwrite;
  logic [63:0] haddr  [3];
  logic [1:0]  hsize  [3];
  logic [63:0] hwdata [3];
  logic [2:0]  hready;
  logic [2:0]  hresp;
  logic [63:0] hrdata [3];

  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();
  dmem_responder_if bus2 ();

  assign bus0.HTRANS = htrans[0]; assign bus0.HWRITE = hwrite[0]; assign bus0.HADDR = haddr[0];
  assign bus0.HSIZE  = hsize[0];  assign bus0.HWDATA = hwdata[0];
  assign bus1.HTRANS = htrans[1]; assign bus1.HWRITE = hwrite[1]; assign bus1.HADDR = haddr[1];
  assign bus1.HSIZE  = hsize[1];  assign bus1.HWDATA = hwdata[1];
  assign bus2.HTRANS = htrans[2]; assign bus2.HWRITE = hwrite[2]; assign bus2.HADDR = haddr[2];
  assign bus2.HSIZE  = hsize[2];  assign bus2.HWDATA = hwdata[2];

  assign hready[0] = bus0.HREADY; assign hresp[0] = bus0.HRESP; assign hrdata[0] = bus0.HRDATA;
  assign hready[1] = bus1.HREADY; assign hresp[1] = bus1.HRESP; assign hrdata[1] = bus1.HRDATA;
  assign hready[2] = bus2.HREADY; assign hresp[2] = bus2.HRESP; assign hrdata[2] = bus2.HRDATA;

  dmem_responder #(.BASE_ADDR(64'h8000_0000), .DEPTH_WORDS(512), .WAIT_STATES(1)) u_dut_ws1 (
    .CLK(CLK), .RESET(rst_n[0]), .bus(bus0));
  dmem_responder #(.BASE_ADDR(64'h8000_0000), .DEPTH_WORDS(512), .WAIT_STATES(0)) u_dut_ws0 (
    .CLK(CLK), .RESET(rst_n[1]), .bus(bus1));
  dmem_responder #(.BASE_ADDR(64'h8000_0000), .DEPTH_WORDS(512), .WAIT_STATES(3)) u_dut_ws3 (
    .CLK(CLK), .RESET(rst_n[2]), .bus(bus2));

  int   total = 0;
  int   bad   = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t cur    [3];
  bit   active [3];
  int   lowcnt [3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic push_exp(input int d, input int low, input bit resp, input logic [63:0] rdata);
    exp_t e;
    e.low   = 4'(low);
    e.resp  = resp;
    e.rdata = rdata;
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_exp(input int d, output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '0;
    case (d)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // Monitor: follows each data phase independently of the stimulus.
  task automatic mon_step(input int d);
    exp_t e;
    bit   ok;
    if (!rst_n[d]) begin
      active[d] = 1'b0;
      return;
    end
    if (active[d]) begin
      if (!hready[d]) begin
        lowcnt[d]++;
        check($sformatf("d%0d_stall_hresp", d), 64'(hresp[d]), 64'(cur[d].resp));
        check($sformatf("d%0d_stall_hrdata", d), hrdata[d], 64'h0);
      end else begin
        check($sformatf("d%0d_stall_cycles", d), 64'(lowcnt[d]), 64'(cur[d].low));
        check($sformatf("d%0d_hresp", d), 64'(hresp[d]), 64'(cur[d].resp));
        check($sformatf("d%0d_hrdata", d), hrdata[d], cur[d].rdata);
        active[d] = 1'b0;
      end
    end else begin
      check($sformatf("d%0d_idle_hready", d), 64'(hready[d]), 64'h1);
      check($sformatf("d%0d_idle_hresp", d), 64'(hresp[d]), 64'h0);
      check($sformatf("d%0d_idle_hrdata", d), hrdata[d], 64'h0);
    end
    if (htrans[d] && hready[d]) begin
      pop_exp(d, e, ok);
      if (!ok) check($sformatf("d%0d_unexpected_accept", d), 64'h1, 64'h0);
      cur[d]    = e;
      active[d] = ok;
      lowcnt[d] = 0;
    end
  endtask

  always @(negedge CLK) begin
    for (int d = 0; d < 3; d++) mon_step(d);
  end

  task automatic timeout_fail(input int d, input string what);
    total++;
    bad++;
    $display("FAIL d%0d_%s_timeout: got no HREADY want HREADY=1 within 50 cycles", d, what);
  endtask

  // Single non-pipelined transfer; HWDATA is held through the data phase.
  task automatic xfer(input int d, input bit wr, input logic [63:0] addr, input logic [1:0] size,
                      input logic [63:0] wdata, input int low, input bit resp,
                      input logic [63:0] rdata);
    int n;
    push_exp(d, low, resp, rdata);
    htrans[d] = 1'b1; hwrite[d] = wr; haddr[d] = addr; hsize[d] = size; hwdata[d] = wdata;
    n = 0;
    while (!hready[d] && n < 50) begin @(posedge CLK); #1; n++; end
    if (n >= 50) timeout_fail(d, "accept");
    @(posedge CLK); #1;
    htrans[d] = 1'b0;
    n = 0;
    while (!hready[d] && n < 50) begin @(posedge CLK); #1; n++; end
    if (n >= 50) timeout_fail(d, "data");
    @(posedge CLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1);
  end

  initial begin
    rst_n  = 3'b000;
    htrans = 3'b000;
    hwrite = 3'b000;
    for (int d = 0; d < 3; d++) begin
      haddr[d] = 64'h0; hsize[d] = 2'd0; hwdata[d] = 64'h0;
      active[d] = 1'b0; lowcnt[d] = 0; cur[d] = '0;
    end
    repeat (2) @(posedge CLK);
    #1 rst_n = 3'b111;
    repeat (3) @(posedge CLK);
    #1;

    // One wait state: doubleword, byte/half merge, errors
    xfer(0, 1, 64'h8000_0010, 2'd3, 64'h1122_3344_5566_7788, 1, 0, 64'h0);
    xfer(0, 0, 64'h8000_0010, 2'd3, 64'h0, 1, 0, 64'h1122_3344_5566_7788);
    xfer(0, 1, 64'h8000_0015, 2'd0, 64'h0000_AB00_0000_0000, 1, 0, 64'h0);
    xfer(0, 1, 64'h8000_0010, 2'd1, 64'h0000_0000_0000_CDEF, 1, 0, 64'h0);
    xfer(0, 0, 64'h8000_0010, 2'd3, 64'h0, 1, 0, 64'h1122_AB44_5566_CDEF);
    xfer(0, 1, 64'h8000_0000, 2'd3, 64'h0A0B_0C0D_0102_0304, 1, 0, 64'h0);
    xfer(0, 0, 64'h7FFF_FFF8, 2'd3, 64'h0, 1, 1, 64'h0);
    xfer(0, 1, 64'h8000_1000, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 64'h0);
    xfer(0, 1, 64'h8000_0012, 2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 64'h0);
    xfer(0, 0, 64'h8000_0000, 2'd3, 64'h0, 1, 0, 64'h0A0B_0C0D_0102_0304);
    xfer(0, 0, 64'h8000_0010, 2'd3, 64'h0, 1, 0, 64'h1122_AB44_5566_CDEF);

    // Zero wait states: back-to-back write then read of the same word
    push_exp(1, 0, 0, 64'h0);
    htrans[1] = 1'b1; hwrite[1] = 1'b1; haddr[1] = 64'h8000_0020; hsize[1] = 2'd3;
    hwdata[1] = 64'hDEAD_BEEF_0000_0001;
    @(posedge CLK); #1;
    push_exp(1, 0, 0, 64'hDEAD_BEEF_0000_0001);
    hwrite[1] = 1'b0;
    @(posedge CLK); #1;
    htrans[1] = 1'b0;
    @(posedge CLK); #1;
    xfer(1, 1, 64'h8000_0024, 2'd2, 64'h1234_5678_0000_0000, 0, 0, 64'h0);
    xfer(1, 0, 64'h8000_0020, 2'd3, 64'h0, 0, 0, 64'h1234_5678_0000_0001);
    xfer(1, 1, 64'h8000_0FF8, 2'd3, 64'h5A5A_0000_FFFF_A5A5, 0, 0, 64'h0);
    xfer(1, 0, 64'h8000_0FF8, 2'd3, 64'h0, 0, 0, 64'h5A5A_0000_FFFF_A5A5);
    xfer(1, 0, 64'h8000_0FFE, 2'd1, 64'h0, 0, 0, 64'h5A5A_0000_FFFF_A5A5);
    xfer(1, 0, 64'h8000_0FFF, 2'd1, 64'h0, 1, 1, 64'h0);

    // Three wait states: reset during the wait of a write aborts it
    xfer(2, 1, 64'h8000_0000, 2'd3, 64'h0123_4567_89AB_CDEF, 3, 0, 64'h0);
    xfer(2, 0, 64'h8000_0000, 2'd3, 64'h0, 3, 0, 64'h0123_4567_89AB_CDEF);
    push_exp(2, 3, 0, 64'h0);
    htrans[2] = 1'b1; hwrite[2] = 1'b1; haddr[2] = 64'h8000_0000; hsize[2] = 2'd3;
    hwdata[2] = 64'h0000_0000_0000_00FF;
    @(posedge CLK); #1;
    htrans[2] = 1'b0;
    @(posedge CLK); #1;
    rst_n[2] = 1'b0;
    @(posedge CLK); #1;
    rst_n[2] = 1'b1;
    check("d2_hready_after_reset", 64'(hready[2]), 64'h1);
    repeat (4) @(posedge CLK);
    #1;
    xfer(2, 0, 64'h8000_0000, 2'd3, 64'h0, 3, 0, 64'h0123_4567_89AB_CDEF);

    repeat (3) @(posedge CLK);
    #1;
    check("d0_queue_empty", 64'(q0.size()), 64'h0);
    check("d1_queue_empty", 64'(q1.size()), 64'h0);
    check("d2_queue_empty", 64'(q2.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
